// File: rtl/colour_sensor_ctrl.sv
`timescale 1ns/1ps
// colour_sensor_ctrl: drives a TCS3200-style sensor, counts R/G/B pulses per gate window
// and classifies the sample into one of six colours (one-hot) or none.
module colour_sensor_ctrl #(
  parameter int SETTLE_CYCLES = 5_000,
  parameter int GATE_CYCLES   = 500_000,
  parameter int CNT_W         = 16,
  parameter int MIN_TOTAL     = 300,
  parameter int BROWN_TOTAL   = 1_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sensor_out,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       led_on,
  output logic       busy,
  output logic [5:0] colour,
  output logic       p2_on,
  output logic       no_match,
  output logic       done
);
  localparam int TW = $clog2(GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES) + 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, CLASSIFY, REPORT} state_t;
  state_t state_q, state_d;
  logic [1:0] filt_q, filt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [5:0] colour_q, colour_d;
  logic [2:0] sync_q;
  logic rise;
  logic [CNT_W+1:0] tot, g4, r3;
  logic [CNT_W:0] g2;
  logic [5:0] cls;
  // sync_q[1:0] is the 2-FF synchroniser, sync_q[2] the previous value for edge detection
  assign rise = sync_q[1] & ~sync_q[2];
  always_comb begin
    tot = (CNT_W+2)'(r_q) + (CNT_W+2)'(g_q) + (CNT_W+2)'(b_q);
    g4  = {g_q, 2'b00};
    r3  = {1'b0, r_q, 1'b0} + {2'b00, r_q};
    g2  = {g_q, 1'b0};
    cls = 32'(tot) < 32'(MIN_TOTAL)           ? 6'b000000 :
          (b_q > r_q && b_q > g_q)            ? 6'b010000 :
          (g_q > r_q && g_q >= b_q)           ? 6'b100000 :
          g4 >= r3                            ? 6'b000100 :
          g2 >= {1'b0, r_q}                   ? 6'b001000 :
          32'(tot) < 32'(BROWN_TOTAL)         ? 6'b000010 : 6'b000001;
  end
  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    tmr_d    = tmr_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        filt_d  = 2'd0;
        tmr_d   = '0;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
      end
      SETTLE: begin
        tmr_d   = tmr_q == SETTLE_LAST ? '0 : tmr_q + 1'b1;
        state_d = tmr_q == SETTLE_LAST ? COUNT : SETTLE;
      end
      COUNT: begin
        r_d = (rise && filt_q == 2'd0 && r_q != '1) ? r_q + 1'b1 : r_q;
        g_d = (rise && filt_q == 2'd1 && g_q != '1) ? g_q + 1'b1 : g_q;
        b_d = (rise && filt_q == 2'd2 && b_q != '1) ? b_q + 1'b1 : b_q;
        tmr_d = tmr_q == GATE_LAST ? '0 : tmr_q + 1'b1;
        if (tmr_q == GATE_LAST) begin
          filt_d  = filt_q == 2'd2 ? 2'd2 : filt_q + 2'd1;
          state_d = filt_q == 2'd2 ? CLASSIFY : SETTLE;
        end
      end
      CLASSIFY: begin
        colour_d = cls;
        state_d  = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      filt_q   <= 2'd0;
      tmr_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      colour_q <= '0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      tmr_q    <= tmr_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      colour_q <= colour_d;
      sync_q   <= {sync_q[1:0], sensor_out};
    end
  end
  // filter codes {s2,s3}: red 00, green 11, blue 01
  assign s0       = 1'b1;
  assign s1       = 1'b0;
  assign s2       = filt_q == 2'd1;
  assign s3       = filt_q != 2'd0;
  assign busy     = state_q != IDLE;
  assign led_on   = busy;
  assign done     = state_q == REPORT;
  assign p2_on    = done & |colour_q;
  assign no_match = done & ~|colour_q;
  assign colour   = colour_q;
endmodule
